tetris_renderer: RTL and testbench

- Read side of the Tetris game state. Consumes the 200-bit fallen-piece board and the three active-square positions from the game logic.
- Converts them into RGB565 pixel data for the 96x64 OLED driver, which supplies pixel_index.
- Holds a per-frame shadow snapshot so a frame never tears mid-scan, and blinks the stack when the game is over.

---
 rtl/tetris_renderer.sv | 109 ++++++++++
 tb/tb_tetris_renderer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tetris_renderer.sv
// Tetris read-side renderer: snapshots the game state once per frame and turns
// pixel_index into RGB565 through a fixed two-stage pipeline.
module tetris_renderer #(
    parameter int          WIDTH      = 10,
    parameter int          HEIGHT     = 20,
    parameter int          X0         = 33,
    parameter int          Y0         = 2,
    parameter logic [15:0] COL_STACK  = 16'h07E0,
    parameter logic [15:0] COL_PIECE  = 16'hF800,
    parameter logic [15:0] COL_BORDER = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_begin,
    input  logic [12:0]               pixel_index,
    input  logic [WIDTH*HEIGHT-1:0]   board,
    input  logic [8:0]                cur_blk1,
    input  logic [8:0]                cur_blk2,
    input  logic [8:0]                cur_blk3,
    input  logic                      game_over,
    output logic [15:0]               pixel_data
);

    localparam int unsigned NCELL = WIDTH * HEIGHT;
    localparam int unsigned PW    = $clog2(NCELL);

    localparam logic [6:0] PF_X0   = 7'(X0);
    localparam logic [6:0] PF_X1   = 7'(X0 + 3 * WIDTH - 1);
    localparam logic [6:0] PF_Y0   = 7'(Y0);
    localparam logic [6:0] PF_Y1   = 7'(Y0 + 3 * HEIGHT - 1);
    localparam logic [6:0] BD_X0   = 7'(X0 - 1);
    localparam logic [6:0] BD_X1   = 7'(X0 + 3 * WIDTH);
    localparam logic [6:0] BD_Y0   = 7'(Y0 - 1);
    localparam logic [6:0] BD_Y1   = 7'(Y0 + 3 * HEIGHT);
    localparam logic [6:0] ROW_TOP = 7'(HEIGHT - 1);
    localparam logic [8:0] HIDE    = 9'(NCELL);
    localparam logic [8:0] W9      = 9'(WIDTH);

    logic [NCELL-1:0] r_board;
    logic [8:0]       r_blk1, r_blk2, r_blk3;
    logic             r_go;
    logic [4:0]       r_frame_cnt;
    logic [6:0]       r_px, r_py;
    logic             r_s1_vld;

    logic [6:0]  w_rx, w_ry, w_col, w_cy, w_dx, w_dy, w_row;
    logic [8:0]  w_pos;
    logic        w_border, w_in_pf, w_gap, w_hit, w_stack;
    logic [15:0] w_pix;

    always_comb begin
        w_rx  = r_px - PF_X0;
        w_ry  = r_py - PF_Y0;
        w_col = w_rx / 7'd3;
        w_dx  = w_rx - w_col * 7'd3;
        w_cy  = w_ry / 7'd3;
        w_dy  = w_ry - w_cy * 7'd3;
        // Row 0 is the bottom of the board, so screen rows count downwards from the top.
        w_row = ROW_TOP - w_cy;
        w_pos = 9'(w_col) + 9'(w_row) * W9;

        w_border = ((r_px == BD_X0 || r_px == BD_X1) && r_py >= BD_Y0 && r_py <= BD_Y1) ||
                   ((r_py == BD_Y0 || r_py == BD_Y1) && r_px >= BD_X0 && r_px <= BD_X1);
        w_in_pf  = r_px >= PF_X0 && r_px <= PF_X1 && r_py >= PF_Y0 && r_py <= PF_Y1;
        w_gap    = (w_dx == 7'd2) || (w_dy == 7'd2);
        w_hit    = (r_blk1 < HIDE && r_blk1 == w_pos) ||
                   (r_blk2 < HIDE && r_blk2 == w_pos) ||
                   (r_blk3 < HIDE && r_blk3 == w_pos);
        // The stack blinks with a 32-frame period once the game has ended.
        w_stack  = r_board[w_pos[PW-1:0]] && (!r_go || !r_frame_cnt[4]);

        w_pix = 16'h0000;
        if (!r_s1_vld)     w_pix = 16'h0000;
        else if (w_border) w_pix = COL_BORDER;
        else if (!w_in_pf) w_pix = 16'h0000;
        else if (w_gap)    w_pix = 16'h0000;
        else if (w_hit)    w_pix = COL_PIECE;
        else if (w_stack)  w_pix = COL_STACK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_board     <= '0;
            r_blk1      <= '1;
            r_blk2      <= '1;
            r_blk3      <= '1;
            r_go        <= 1'b0;
            r_frame_cnt <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_s1_vld    <= 1'b0;
            pixel_data  <= '0;
        end else begin
            if (frame_begin) begin
                r_board     <= board;
                r_blk1      <= cur_blk1;
                r_blk2      <= cur_blk2;
                r_blk3      <= cur_blk3;
                r_go        <= game_over;
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end
            r_px       <= 7'(pixel_index % 13'd96);
            r_py       <= 7'(pixel_index / 13'd96);
            r_s1_vld   <= pixel_index < 13'd6144;
            pixel_data <= w_pix;
        end
    end

endmodule

// File: tb/tb_tetris_renderer.sv
// Bench for tetris_renderer: constant vectors, directed multi-cycle sequences and
// random stimulus compared every cycle against a rule-level pixel model.
module tb_tetris_renderer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_begin = 1'b0;
    logic [12:0]  pixel_index = '0;
    logic [199:0] board = '0;
    logic [8:0]   cur_blk1 = 9'h1FF, cur_blk2 = 9'h1FF, cur_blk3 = 9'h1FF;
    logic         game_over = 1'b0;
    logic [15:0]  pixel_data;

    tetris_renderer #(.WIDTH(10), .HEIGHT(20), .X0(33), .Y0(2)) dut (
        .clk(clk), .rst(rst), .frame_begin(frame_begin), .pixel_index(pixel_index),
        .board(board), .cur_blk1(cur_blk1), .cur_blk2(cur_blk2), .cur_blk3(cur_blk3),
        .game_over(game_over), .pixel_data(pixel_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: what the renderer should have captured at the last frame start.
    bit [199:0] m_board;
    int         m_blk[3];
    bit         m_go;
    int         m_cnt;
    int         m_idx;
    bit [15:0]  m_exp;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_board = '0;
        for (int i = 0; i < 3; i++) m_blk[i] = 511;
        m_go  = 0;
        m_cnt = 0;
        m_idx = 0;
        m_exp = 16'h0000;
    endtask

    function automatic bit [15:0] ref_pix(input int idx);
        int px, py, cx, cy, pos;
        if (idx >= 6144) return 16'h0000;
        px = idx % 96;
        py = idx / 96;
        if (((px == 32 || px == 63) && py >= 1 && py <= 62) ||
            ((py == 1 || py == 62) && px >= 32 && px <= 63)) return 16'hFFFF;
        if (px < 33 || px > 62 || py < 2 || py > 61) return 16'h0000;
        cx = px - 33;
        cy = py - 2;
        if (cx % 3 == 2 || cy % 3 == 2) return 16'h0000;
        pos = cx / 3 + (19 - cy / 3) * 10;
        foreach (m_blk[i]) if (m_blk[i] < 200 && m_blk[i] == pos) return 16'hF800;
        if (m_board[pos] && (!m_go || m_cnt < 16)) return 16'h07E0;
        return 16'h0000;
    endfunction

    // One clock: advance the model in lockstep, then compare just after the edge.
    task automatic step();
        bit [15:0] nxt;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            nxt = ref_pix(m_idx);
            if (frame_begin) begin
                m_board  = board;
                m_blk[0] = cur_blk1;
                m_blk[1] = cur_blk2;
                m_blk[2] = cur_blk3;
                m_go     = game_over;
                m_cnt    = (m_cnt + 1) % 32;
            end
            m_idx = pixel_index;
            m_exp = nxt;
        end
        #1;
        check("model", pixel_data, m_exp);
    endtask

    task automatic snapshot();
        frame_begin = 1'b1;
        step();
        frame_begin = 1'b0;
    endtask

    task automatic show(input logic [12:0] idx);
        pixel_index = idx;
        step();
        step();
    endtask

    typedef struct {
        string       name;
        logic [12:0] idx;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{"cell_34_3",     13'd322,  16'h07E0};
        tbl[1]  = '{"border_corner", 13'd128,  16'hFFFF};
        tbl[2]  = '{"gap_col",       13'd323,  16'h0000};
        tbl[3]  = '{"out_of_range",  13'd6200, 16'h0000};
        tbl[4]  = '{"piece_195",     13'd240,  16'hF800};
        tbl[5]  = '{"origin",        13'd0,    16'h0000};
        tbl[6]  = '{"border_right",  13'd2943, 16'hFFFF};
        tbl[7]  = '{"above_border",  13'd32,   16'h0000};
        tbl[8]  = '{"border_bottom", 13'd5992, 16'hFFFF};
        tbl[9]  = '{"gap_corner",    13'd5918, 16'h0000};
        tbl[10] = '{"cell_pos9",     13'd5821, 16'h07E0};
        tbl[11] = '{"idx_6144",      13'd6144, 16'h0000};

        model_reset();
        step();
        step();
        check("reset_out", pixel_data, 16'h0000);
        rst = 1'b0;

        // No snapshot yet: only the frame can ever light up.
        for (int i = 0; i < 24; i++) begin
            pixel_index = 13'($urandom_range(0, 8191));
            step();
        end

        board    = '1;
        cur_blk1 = 9'd195;
        cur_blk2 = 9'd300;
        cur_blk3 = 9'h1FF;
        pixel_index = 13'd322;
        snapshot();
        step();
        check("first_pixel", pixel_data, 16'h07E0);

        for (int i = 0; i < 12; i++) begin
            show(tbl[i].idx);
            check(tbl[i].name, pixel_data, tbl[i].exp);
        end

        // Mid-frame board change must stay invisible until the next frame start.
        board = '0;
        board[0] = 1'b1;
        cur_blk1 = 9'h1FF;
        cur_blk2 = 9'h1FF;
        pixel_index = 13'd5697;
        snapshot();
        step();
        check("pos0_set", pixel_data, 16'h07E0);
        board = '0;
        for (int i = 0; i < 4; i++) step();
        check("midframe_hold", pixel_data, 16'h07E0);
        snapshot();
        step();
        check("after_frame", pixel_data, 16'h0000);

        // Game-over blink across a full counter wrap.
        board[0] = 1'b1;
        game_over = 1'b1;
        for (int k = 0; k < 40; k++) begin
            snapshot();
            step();
            step();
            check("blink", pixel_data, (m_cnt < 16) ? 16'h07E0 : 16'h0000);
        end
        game_over = 1'b0;

        // Random traffic with occasional frame starts and mid-frame input churn.
        for (int c = 0; c < 3000; c++) begin
            frame_begin = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) pixel_index = 13'($urandom_range(0, 8191));
            else pixel_index = 13'($urandom_range(30, 65) + 96 * $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0)
                for (int b = 0; b < 200; b++) board[b] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cur_blk1 = 9'($urandom_range(0, 220));
            if ($urandom_range(0, 3) == 0) cur_blk2 = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) cur_blk3 = 9'($urandom_range(180, 205));
            if ($urandom_range(0, 31) == 0) game_over = ~game_over;
            step();
        end
        frame_begin = 1'b0;

        // Async reset between edges clears the output and the captured piece.
        board = '0;
        game_over = 1'b0;
        cur_blk1 = 9'd0;
        cur_blk2 = 9'h1FF;
        cur_blk3 = 9'h1FF;
        pixel_index = 13'd5697;
        snapshot();
        step();
        check("piece_pos0", pixel_data, 16'hF800);
        #2 rst = 1'b1;
        #1 check("async_rst", pixel_data, 16'h0000);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("after_rst", pixel_data, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
